dma_engine: RTL and testbench

- Memory-to-memory DMA engine that services the core's DMA command interface.
- The core issues one command pulse carrying an op (funct3), a length (imm) and two addresses (rs1, rs2).
- The engine holds busy while it moves words over the shared data-memory port (req/gnt, synchronous 1-cycle read latency), then drops busy so the core resumes.
- Sits beside the core on the data-memory arbiter; the core suppresses its own data requests while busy is high.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_engine.sv | 136 +++++++++++++
 tb/tb_dma_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types and constants; also imported by the core's DMA command decode.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DATA,
    WR,
    DONE
  } dma_state_e;

  localparam logic [2:0] DMA_OP_COPY   = 3'b000;
  localparam logic [2:0] DMA_OP_FILL   = 3'b001;
  localparam logic [3:0] DMA_SIZE_WORD = 4'b1111;

endpackage

// File: rtl/dma_engine.sv
// Word-granular COPY/FILL DMA on the shared data port; COPY 3 cycles/word, FILL 1 cycle/word, +1 DONE cycle.
// Waits on gnt_i with all port outputs held; commands arriving while busy are dropped and flag err.
module dma_engine
  import dma_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dma_en_i,
  input  logic [2:0]       dma_funct3_i,
  input  logic [LEN_W-1:0] dma_imm_i,
  input  logic [XLEN-1:0]  dma_rs1_i,
  input  logic [XLEN-1:0]  dma_rs2_i,
  output logic             dma_busy_o,
  output logic             dma_done_o,
  output logic             dma_err_o,
  output logic             req_o,
  input  logic             gnt_i,
  output logic [XLEN-1:0]  addr_o,
  output logic [XLEN-1:0]  wr_data_o,
  input  logic [XLEN-1:0]  rd_data_i,
  output logic [3:0]       size_o,
  output logic             read_o,
  output logic             write_o
);

  dma_state_e       state_q, state_d;
  logic [XLEN-1:0]  src_q, dst_q, fill_q, buf_q;
  logic [LEN_W-1:0] cnt_q;
  logic             fill_mode_q;
  logic             err_q;
  logic             cmd_legal;
  logic             cmd_start;

  assign cmd_legal = (dma_funct3_i == DMA_OP_COPY) || (dma_funct3_i == DMA_OP_FILL);
  assign cmd_start = dma_en_i && cmd_legal && (dma_imm_i != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_start) state_d = (dma_funct3_i == DMA_OP_FILL) ? WR : RD;
      end
      RD: begin
        if (gnt_i) state_d = RD_DATA;
      end
      RD_DATA: state_d = WR;
      WR: begin
        if (gnt_i) begin
          if (cnt_q == LEN_W'(1)) state_d = DONE;
          else if (!fill_mode_q)  state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers only move on accepted commands, read returns and granted writes,
  // so every port output is frozen during wait states.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q       <= '0;
      dst_q       <= '0;
      fill_q      <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      fill_mode_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dma_en_i && !cmd_legal) begin
            err_q <= 1'b1;
          end else if (cmd_start) begin
            src_q       <= {dma_rs1_i[XLEN-1:2], 2'b00};
            fill_q      <= dma_rs1_i;
            dst_q       <= {dma_rs2_i[XLEN-1:2], 2'b00};
            cnt_q       <= dma_imm_i;
            fill_mode_q <= (dma_funct3_i == DMA_OP_FILL);
            err_q       <= 1'b0;
          end
        end
        RD_DATA: begin
          buf_q <= rd_data_i;
          src_q <= src_q + XLEN'(4);
        end
        WR: begin
          if (gnt_i) begin
            dst_q <= dst_q + XLEN'(4);
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
      if (dma_en_i && (state_q != IDLE)) err_q <= 1'b1;
    end
  end

  always_comb begin
    req_o     = 1'b0;
    read_o    = 1'b0;
    write_o   = 1'b0;
    addr_o    = '0;
    wr_data_o = '0;
    size_o    = '0;
    case (state_q)
      RD: begin
        req_o  = 1'b1;
        read_o = 1'b1;
        addr_o = src_q;
        size_o = DMA_SIZE_WORD;
      end
      WR: begin
        req_o     = 1'b1;
        write_o   = 1'b1;
        addr_o    = dst_q;
        wr_data_o = fill_mode_q ? fill_q : buf_q;
        size_o    = DMA_SIZE_WORD;
      end
      default: ;
    endcase
  end

  assign dma_busy_o = (state_q != IDLE);
  assign dma_done_o = (state_q == DONE);
  assign dma_err_o  = err_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: behavioural 1-cycle-latency memory, programmable grant delay.
module tb_dma_engine;
  import dma_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        dma_en_i = 1'b0;
  logic [2:0]  dma_funct3_i = '0;
  logic [11:0] dma_imm_i = '0;
  logic [31:0] dma_rs1_i = '0;
  logic [31:0] dma_rs2_i = '0;
  logic        dma_busy_o, dma_done_o, dma_err_o;
  logic        req_o, gnt_i, read_o, write_o;
  logic [31:0] addr_o, wr_data_o;
  logic [31:0] rd_data_i = '0;
  logic [3:0]  size_o;

  dma_engine #(.XLEN(32), .LEN_W(12)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dma_en_i(dma_en_i), .dma_funct3_i(dma_funct3_i),
    .dma_imm_i(dma_imm_i), .dma_rs1_i(dma_rs1_i), .dma_rs2_i(dma_rs2_i),
    .dma_busy_o(dma_busy_o), .dma_done_o(dma_done_o), .dma_err_o(dma_err_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .wr_data_o(wr_data_o),
    .rd_data_i(rd_data_i), .size_o(size_o), .read_o(read_o), .write_o(write_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory: grant after gnt_delay cycles of waiting, access at the grant edge.
  logic [31:0] mem [0:1023];
  int          gnt_delay = 0;
  int          wait_ctr = 0;
  assign gnt_i = req_o && (wait_ctr >= gnt_delay);

  always @(posedge clk_i) begin
    if (req_o && !gnt_i) wait_ctr <= wait_ctr + 1;
    else                 wait_ctr <= 0;
    if (req_o && gnt_i && write_o) mem[addr_o[11:2]] <= wr_data_o;
    if (req_o && gnt_i && read_o)  rd_data_i <= mem[addr_o[11:2]];
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Per-command statistics, sampled 1 ns after each rising edge.
  int          cyc = 0;
  int          busy_cnt, done_cnt, rd_cnt, req_cnt, stable_err, last_busy, done_at;
  logic        seen_rd, was_wait;
  logic [31:0] first_rd;
  logic [69:0] prev_out;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  task automatic clear_stats();
    busy_cnt = 0; done_cnt = 0; rd_cnt = 0; req_cnt = 0; stable_err = 0;
    last_busy = -1; done_at = -2; seen_rd = 1'b0; was_wait = 1'b0; first_rd = '0;
    prev_out = '0;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (dma_busy_o) begin busy_cnt++; last_busy = cyc; end
    if (dma_done_o) begin done_cnt++; done_at = cyc; end
    if (read_o) rd_cnt++;
    if (req_o) req_cnt++;
    if (req_o && read_o && !seen_rd) begin seen_rd = 1'b1; first_rd = addr_o; end
    if (req_o && gnt_i && write_o) begin
      wa_q.push_back(addr_o); wd_q.push_back(wr_data_o); wc_q.push_back(cyc);
    end
    if (was_wait && ({addr_o, wr_data_o, read_o, write_o, size_o} != prev_out)) stable_err++;
    was_wait = req_o && !gnt_i;
    prev_out = {addr_o, wr_data_o, read_o, write_o, size_o};
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    dma_funct3_i = f3; dma_imm_i = imm; dma_rs1_i = rs1; dma_rs2_i = rs2;
    dma_en_i = 1'b1;
    tick();
    dma_en_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 500 && dma_busy_o; n++) tick();
    check(tag, dma_busy_o, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    for (int i = 0; i < 5; i++) mem[(32'h100 >> 2) + i] <= 32'hA0 + 32'(i);
    mem[32'h140 >> 2] <= 32'h11;
    mem[32'h144 >> 2] <= 32'h22;
    mem[32'h600 >> 2] <= 32'h1234;

    clear_stats();
    repeat (3) tick();
    check("rst_busy", dma_busy_o, 1'b0);
    check("rst_done", dma_done_o, 1'b0);
    check("rst_err", dma_err_o, 1'b0);
    check("rst_port", {req_o, read_o, write_o, size_o}, 7'h0);
    check("rst_addr", addr_o, 32'h0);
    check("rst_wdata", wr_data_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    // COPY 4 words, gnt immediate: 4 x 3 + DONE = 13 busy cycles.
    clear_stats();
    issue(DMA_OP_COPY, 12'd4, 32'h100, 32'h200);
    wait_idle("copy4_tmo");
    for (int i = 0; i < 4; i++) check("copy4_data", mem[(32'h200 >> 2) + i], 32'hA0 + 32'(i));
    check("copy4_busy", busy_cnt, 13);
    check("copy4_done_cnt", done_cnt, 1);
    check("copy4_done_last", done_at, last_busy);

    // FILL 3 words: back-to-back writes, 3 + DONE = 4 busy cycles.
    clear_stats();
    issue(DMA_OP_FILL, 12'd3, 32'hDEADBEEF, 32'h300);
    wait_idle("fill3_tmo");
    check("fill3_busy", busy_cnt, 4);
    check("fill3_reads", rd_cnt, 0);
    check("fill3_nwr", wa_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("fill3_addr", wa_q[i], 32'h300 + 32'(4 * i));
      check("fill3_data", wd_q[i], 32'hDEADBEEF);
    end
    check("fill3_consec", wc_q[2] - wc_q[0], 2);

    // COPY 2 words, each request waits 3 cycles: 2 x 3 + DONE + 4 x 3 = 19 busy cycles.
    clear_stats();
    gnt_delay = 3;
    issue(DMA_OP_COPY, 12'd2, 32'h140, 32'h240);
    wait_idle("wait_tmo");
    gnt_delay = 0;
    check("wait_busy", busy_cnt, 19);
    check("wait_req_cycles", req_cnt, 16);
    check("wait_stable", stable_err, 0);
    check("wait_data0", mem[32'h240 >> 2], 32'h11);
    check("wait_data1", mem[32'h244 >> 2], 32'h22);

    // Unaligned addresses are truncated to word boundaries.
    clear_stats();
    issue(DMA_OP_COPY, 12'd1, 32'h103, 32'h906);
    wait_idle("unal_tmo");
    check("unal_rd_addr", first_rd, 32'h100);
    check("unal_wr_addr", wa_q[0], 32'h904);
    check("unal_data", mem[32'h904 >> 2], 32'hA0);

    // Illegal op flags err and never goes busy; next legal command clears it.
    clear_stats();
    issue(3'b111, 12'd2, 32'h0, 32'h0);
    repeat (2) tick();
    check("ill_err", dma_err_o, 1'b1);
    check("ill_busy", busy_cnt, 0);
    issue(DMA_OP_FILL, 12'd1, 32'h5, 32'h400);
    check("clr_err", dma_err_o, 1'b0);
    wait_idle("clr_tmo");
    check("clr_data", mem[32'h400 >> 2], 32'h5);

    // Zero length is a silent no-op.
    clear_stats();
    issue(DMA_OP_COPY, 12'd0, 32'h100, 32'hA00);
    repeat (3) tick();
    check("zero_busy", busy_cnt, 0);
    check("zero_done", done_cnt, 0);
    check("zero_req", req_cnt, 0);

    // Command during a transfer is ignored and flags err.
    clear_stats();
    issue(DMA_OP_FILL, 12'd5, 32'h77, 32'h500);
    tick();
    issue(DMA_OP_COPY, 12'd1, 32'h100, 32'h600);
    wait_idle("busy_cmd_tmo");
    check("busy_cmd_err", dma_err_o, 1'b1);
    check("busy_cmd_busy", busy_cnt, 6);
    check("busy_cmd_nwr", wa_q.size(), 5);
    check("busy_cmd_last", wa_q[4], 32'h510);
    check("busy_cmd_data", mem[32'h510 >> 2], 32'h77);
    check("busy_cmd_untouched", mem[32'h600 >> 2], 32'h1234);

    // Reset while writing word 2 of 5 aborts cleanly.
    clear_stats();
    issue(DMA_OP_COPY, 12'd5, 32'h100, 32'h700);
    repeat (5) tick();
    check("abort_in_wr", {req_o, write_o}, 2'b11);
    check("abort_wr_addr", addr_o, 32'h704);
    rst_ni = 1'b0;
    tick();
    check("abort_busy", dma_busy_o, 1'b0);
    check("abort_err", dma_err_o, 1'b0);
    check("abort_port", {req_o, read_o, write_o, dma_done_o, size_o}, 8'h0);
    check("abort_addr", addr_o, 32'h0);
    rst_ni = 1'b1;
    tick();
    check("abort_no_w3", mem[32'h708 >> 2], 32'h0);
    clear_stats();
    issue(DMA_OP_COPY, 12'd1, 32'h100, 32'h800);
    wait_idle("post_rst_tmo");
    check("post_rst_data", mem[32'h800 >> 2], 32'hA0);
    check("post_rst_busy", busy_cnt, 4);
    check("post_rst_done", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
